// File: rtl/counter_sequencer.sv
// counter_sequencer: up/down counter sequencer with prescaler, one-shot/auto-reload and terminal-count pulse
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int PS_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PS_W-1:0]  prescale,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_n, sl, s_val, t_val;
  logic [PS_W-1:0] ps, ps_n, sp;
  logic smode, sdir, tc_n, tick, at_t;
  assign s_val = sdir ? sl : '0;
  assign t_val = sdir ? '0 : sl;
  assign tick = ps == sp;
  assign at_t = Q == t_val;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      Q <= '0;
      ps <= '0;
      tc <= 1'b0;
      smode <= 1'b0;
      sdir <= 1'b0;
      sl <= '0;
      sp <= '0;
    end else begin
      state <= state_n;
      Q <= q_n;
      ps <= ps_n;
      tc <= tc_n;
      if (start && !stop) begin
        smode <= mode;
        sdir <= dir;
        sl <= load_val;
        sp <= prescale;
      end
    end
  end
  always_comb begin
    state_n = state;
    q_n = Q;
    ps_n = ps;
    tc_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      q_n = '0;
      ps_n = '0;
    end else if (start) begin
      state_n = RUN;
      q_n = dir ? load_val : '0;
      ps_n = '0;
    end else if (state == RUN) begin
      ps_n = tick ? '0 : ps + 1'b1;
      if (tick) begin
        tc_n = at_t;
        q_n = !at_t ? (sdir ? Q - 1'b1 : Q + 1'b1) : (smode ? s_val : Q);
        state_n = (at_t && !smode) ? DONE : RUN;
      end
    end
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized and directed checks of counter_sequencer against an elapsed-time reference model
module tb_counter_sequencer;
  localparam int W = 4;
  localparam int P_W = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic mode = 1'b0;
  logic dir = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [P_W-1:0] prescale = '0;
  logic [W-1:0] q;
  logic busy, tc, done;
  int checks = 0;
  int errors = 0;
  int m_st = 0;
  int m_k = 0;
  int m_mode = 0;
  int m_dir = 0;
  int m_l = 0;
  int m_p = 0;
  int m_tc = 0;
  counter_sequencer #(.WIDTH(W), .PS_W(P_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .load_val(load_val), .prescale(prescale), .Q(q), .busy(busy), .tc(tc), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int mq();
    int idx;
    if (m_st == 0) return 0;
    if (m_st == 2) return m_dir ? 0 : m_l;
    idx = m_k / (m_p + 1);
    return m_dir ? m_l - idx : idx;
  endfunction
  task automatic model_edge();
    m_tc = 0;
    if (stop) m_st = 0;
    else if (start) begin
      m_st = 1;
      m_k = 0;
      m_mode = int'(mode);
      m_dir = int'(dir);
      m_l = int'(load_val);
      m_p = int'(prescale);
    end else if (m_st == 1) begin
      m_k++;
      if (m_k == (m_l + 1) * (m_p + 1)) begin
        m_tc = 1;
        if (m_mode == 1) m_k = 0;
        else m_st = 2;
      end
    end
  endtask
  task automatic check_outputs(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(mq()));
    chk({tag, "_busy"}, 32'(busy), 32'(m_st == 1));
    chk({tag, "_tc"}, 32'(tc), 32'(m_tc));
    chk({tag, "_done"}, 32'(done), 32'(m_st == 2));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask
  task automatic go(input logic md, input logic dr, input int l, input int p);
    mode = md;
    dir = dr;
    load_val = W'(l);
    prescale = P_W'(p);
    start = 1'b1;
    step("start");
    start = 1'b0;
  endtask
  initial begin
    int n;
    #12;
    check_outputs("rst");
    reset = 1'b0;
    repeat (2) step("idle");
    go(0, 0, 7, 0);
    repeat (3) step("t1_run");
    #2 reset = 1'b1;
    #1;
    m_st = 0;
    m_tc = 0;
    check_outputs("async_rst");
    chk("async_rst_q0", 32'(q), 0);
    #1 reset = 1'b0;
    repeat (3) step("t1_idle");
    go(0, 0, 5, 0);
    chk("t2_q_start", 32'(q), 0);
    for (int i = 1; i <= 5; i++) begin
      step("t2");
      chk("t2_q", 32'(q), 32'(i));
    end
    step("t2_term");
    chk("t2_tc", 32'(tc), 1);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_qhold", 32'(q), 5);
    step("t2_after");
    chk("t2_tc_clr", 32'(tc), 0);
    go(1, 1, 3, 1);
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step("t3");
      n += int'(tc);
    end
    chk("t3_busy", 32'(busy), 1);
    chk("t3_tc_count", 32'(n), 3);
    start = 1'b1;
    stop = 1'b1;
    step("t4");
    start = 1'b0;
    stop = 1'b0;
    chk("t4_q", 32'(q), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_tc", 32'(tc), 0);
    go(0, 0, 0, 0);
    chk("t5_q", 32'(q), 0);
    step("t5");
    chk("t5_tc", 32'(tc), 1);
    chk("t5_done", 32'(done), 1);
    go(0, 0, 9, 0);
    load_val = 4'd2;
    dir = 1'b1;
    n = 0;
    while (mq() != 4 && n < 20) begin
      step("t6_up");
      n++;
    end
    chk("t6_reach4", 32'(q), 4);
    start = 1'b1;
    step("t6_restart");
    start = 1'b0;
    chk("t6_q2", 32'(q), 2);
    step("t6");
    chk("t6_q1", 32'(q), 1);
    step("t6");
    chk("t6_q0", 32'(q), 0);
    step("t6");
    chk("t6_tc", 32'(tc), 1);
    chk("t6_done", 32'(done), 1);
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 39) == 0);
      mode = 1'($urandom);
      dir = 1'($urandom);
      load_val = W'($urandom);
      prescale = ($urandom_range(0, 7) == 0) ? P_W'($urandom) : P_W'($urandom_range(0, 2));
      step("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
